// File: rtl/instruction_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit_if
// Bundles the fetch stage's control inputs, its instruction-memory port and
// its IF/ID pipeline-register outputs.
//   master : fetch unit side (drives address and IF/ID, samples controls)
//   slave  : surrounding pipeline / memory side
// Signals:
//   stall, flush, redirect_valid, redirect_pc  control from later stages
//   Instruction                                word from instruction memory
//   Inst_Address                               fetch byte address (= pc)
//   if_id_pc, if_id_instr, if_id_valid         IF/ID pipeline register
//   fetch_fault                                sticky illegal-fetch flag
//   fetch_count                                instructions captured
// ---------------------------------------------------------------------------
interface instruction_fetch_unit_if #(
    parameter int CNT_W = 32
);
    logic             stall;
    logic             flush;
    logic             redirect_valid;
    logic [63:0]      redirect_pc;
    logic [31:0]      Instruction;
    logic [63:0]      Inst_Address;
    logic [63:0]      if_id_pc;
    logic [31:0]      if_id_instr;
    logic             if_id_valid;
    logic             fetch_fault;
    logic [CNT_W-1:0] fetch_count;

    modport master (
        input  stall, flush, redirect_valid, redirect_pc, Instruction,
        output Inst_Address, if_id_pc, if_id_instr, if_id_valid,
               fetch_fault, fetch_count
    );

    modport slave (
        output stall, flush, redirect_valid, redirect_pc, Instruction,
        input  Inst_Address, if_id_pc, if_id_instr, if_id_valid,
               fetch_fault, fetch_count
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage. Owns the PC, presents it as the byte address of a
// combinational instruction memory and captures the returned word into the
// IF/ID register. Later stages may stall, flush or redirect the fetch.
// A misaligned or out-of-range PC sends the unit into a terminal FAULT
// state that only reset leaves.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset
//   bus      instruction_fetch_unit_if.master (controls, memory, IF/ID)
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter int          MEM_BYTES = 96,
    parameter int          CNT_W     = 32
) (
    input  logic                            clk,
    input  logic                            reset_n,
    instruction_fetch_unit_if.master        bus
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [64:0] MEM_LIMIT = 65'(MEM_BYTES);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state;
    logic [63:0]      pc;
    logic [63:0]      if_id_pc_q;
    logic [31:0]      if_id_instr_q;
    logic             if_id_valid_q;
    logic             fetch_fault_q;
    logic [CNT_W-1:0] fetch_count_q;

    logic [64:0]      pc_last_byte;
    logic             fetch_illegal;

    // Last byte of the word is computed in 65 bits so a PC near 2^64 cannot
    // wrap around and appear to be in range.
    assign pc_last_byte  = {1'b0, pc} + 65'd3;
    assign fetch_illegal = (pc[1:0] != 2'b00) || (pc_last_byte >= MEM_LIMIT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            if_id_pc_q    <= 64'h0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end

                RUN: begin
                    // The address check outranks redirect/flush/stall so an
                    // illegal PC is never captured, even while stalled.
                    if (fetch_illegal) begin
                        state         <= FAULT;
                        fetch_fault_q <= 1'b1;
                        if_id_valid_q <= 1'b0;
                    end else if (bus.redirect_valid) begin
                        pc            <= bus.redirect_pc;
                        if_id_valid_q <= 1'b0;
                    end else if (bus.flush) begin
                        if_id_valid_q <= 1'b0;
                    end else if (!bus.stall) begin
                        if_id_instr_q <= bus.Instruction;
                        if_id_pc_q    <= pc;
                        if_id_valid_q <= 1'b1;
                        pc            <= pc + 64'd4;
                        fetch_count_q <= fetch_count_q + 1'b1;
                    end
                end

                FAULT: begin
                    state <= FAULT;
                end

                default: begin
                    state <= FAULT;
                end
            endcase
        end
    end

    assign bus.Inst_Address = pc;
    assign bus.if_id_pc     = if_id_pc_q;
    assign bus.if_id_instr  = if_id_instr_q;
    assign bus.if_id_valid  = if_id_valid_q;
    assign bus.fetch_fault  = fetch_fault_q;
    assign bus.fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch_unit
// Directed stimulus with a scoreboard: each cycle expected to capture an
// instruction pushes its expected IF/ID contents; a monitor pops and compares
// whenever the DUT reports a new capture. Cycle-level state (address, valid,
// fault, count) is checked directly by the stimulus thread.
// ---------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam int MEM_BYTES = 96;
    localparam int WORDS     = MEM_BYTES / 4;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
        logic [31:0] cnt;
    } exp_t;

    logic clk;
    logic reset_n;

    instruction_fetch_unit_if #(.CNT_W(32)) bus ();

    instruction_fetch_unit #(
        .RESET_PC (64'h0),
        .MEM_BYTES(MEM_BYTES),
        .CNT_W    (32)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    logic [31:0] mem [WORDS];
    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_count = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory; out-of-range reads return a marker.
    always_comb begin
        bus.Instruction = 32'hDEAD_BEEF;
        if (bus.Inst_Address < 64'(MEM_BYTES))
            bus.Instruction = mem[bus.Inst_Address[6:2]];
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_capture(input logic [63:0] pc, input logic [31:0] cnt);
        exp_t e;
        e.pc    = pc;
        e.instr = mem[pc[6:2]];
        e.cnt   = cnt;
        exp_q.push_back(e);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_addr"},  bus.Inst_Address, 64'h0);
        check({tag, "_ifpc"},  bus.if_id_pc,     64'h0);
        check({tag, "_instr"}, 64'(bus.if_id_instr), 64'h13);
        check({tag, "_valid"}, 64'(bus.if_id_valid), 64'h0);
        check({tag, "_fault"}, 64'(bus.fetch_fault), 64'h0);
        check({tag, "_count"}, 64'(bus.fetch_count), 64'h0);
    endtask

    // Scoreboard monitor: a capture shows up as a valid IF/ID with a new count.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.if_id_valid && bus.fetch_count != last_count) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_capture", 64'(bus.fetch_count), 64'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_pc",    bus.if_id_pc,            e.pc);
                    check("sb_instr", 64'(bus.if_id_instr),    64'(e.instr));
                    check("sb_count", 64'(bus.fetch_count),    64'(e.cnt));
                end
            end
            last_count = bus.fetch_count;
        end
    end

    initial begin
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h1000_0000 | 32'(i);
        mem[0] = 32'h1000_0513;
        mem[1] = 32'h00a0_0593;
        mem[2] = 32'h00b5_0633;
        mem[3] = 32'h045b_0463;

        bus.stall          = 1'b0;
        bus.flush          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        reset_n            = 1'b1;
        #2 reset_n = 1'b0;
        #1 check_reset_state("rst");
        tick();
        check_reset_state("rst_clk");
        reset_n = 1'b1;

        // BOOT cycle, then first capture.
        tick();
        check("boot_addr",  bus.Inst_Address, 64'h0);
        check("boot_valid", 64'(bus.if_id_valid), 64'h0);
        push_capture(64'h0, 32'd1);
        tick();
        check("t1_addr",  bus.Inst_Address, 64'h4);
        check("t1_valid", 64'(bus.if_id_valid), 64'h1);
        check("t1_count", 64'(bus.fetch_count), 64'h1);
        push_capture(64'h4, 32'd2);
        tick();

        // Stall three cycles at pc=8.
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_addr",  bus.Inst_Address, 64'h8);
            check("stall_count", 64'(bus.fetch_count), 64'h2);
            check("stall_ifpc",  bus.if_id_pc, 64'h4);
        end
        bus.stall = 1'b0;
        push_capture(64'h8, 32'd3);
        tick();
        check("unstall_addr", bus.Inst_Address, 64'hC);
        push_capture(64'hC, 32'd4);
        tick();
        check("seq_addr", bus.Inst_Address, 64'h10);

        // Redirect wins over stall in the same cycle.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hC;
        bus.stall          = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        check("redir_addr",  bus.Inst_Address, 64'hC);
        check("redir_valid", 64'(bus.if_id_valid), 64'h0);
        check("redir_count", 64'(bus.fetch_count), 64'h4);
        push_capture(64'hC, 32'd5);
        tick();
        check("redir_cap_instr", 64'(bus.if_id_instr), 64'h045b_0463);
        check("redir_next_addr", bus.Inst_Address, 64'h10);

        // Flush kills IF/ID and holds pc.
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_valid", 64'(bus.if_id_valid), 64'h0);
        check("flush_addr",  bus.Inst_Address, 64'h10);
        check("flush_count", 64'(bus.fetch_count), 64'h5);

        // Redirect to an illegal target: accepted, then fault.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h62;
        tick();
        bus.redirect_valid = 1'b0;
        check("bad_redir_addr",  bus.Inst_Address, 64'h62);
        check("bad_redir_fault", 64'(bus.fetch_fault), 64'h0);
        tick();
        check("fault_set",   64'(bus.fetch_fault), 64'h1);
        check("fault_valid", 64'(bus.if_id_valid), 64'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h0;
        bus.stall          = 1'b1;
        tick();
        tick();
        bus.redirect_valid = 1'b0;
        bus.stall          = 1'b0;
        tick();
        check("fault_hold_addr",  bus.Inst_Address, 64'h62);
        check("fault_hold_fault", 64'(bus.fetch_fault), 64'h1);
        check("fault_hold_count", 64'(bus.fetch_count), 64'h5);

        // Asynchronous reset between edges.
        #2 reset_n = 1'b0;
        #1 check_reset_state("async_rst");
        reset_n = 1'b1;
        tick();
        check("reboot_addr",  bus.Inst_Address, 64'h0);
        check("reboot_valid", 64'(bus.if_id_valid), 64'h0);

        // Sequential run over the whole memory, then fault at pc=96.
        for (int i = 0; i < WORDS; i++) begin
            push_capture(64'(i * 4), 32'(i + 1));
            tick();
        end
        check("end_addr",  bus.Inst_Address, 64'd96);
        check("end_count", 64'(bus.fetch_count), 64'd24);
        check("end_fault", 64'(bus.fetch_fault), 64'h0);
        tick();
        check("oob_fault", 64'(bus.fetch_fault), 64'h1);
        check("oob_valid", 64'(bus.if_id_valid), 64'h0);
        check("oob_count", 64'(bus.fetch_count), 64'd24);
        check("oob_addr",  bus.Inst_Address, 64'd96);

        // Misaligned redirect after a fresh reset.
        #2 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h2;
        tick();
        bus.redirect_valid = 1'b0;
        tick();
        check("misalign_fault", 64'(bus.fetch_fault), 64'h1);
        check("misalign_addr",  bus.Inst_Address, 64'h2);

        @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'h0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
